// File: rtl/types_pkg.sv
// Shared link-layer types: flit layout, checksum helper and receive FSM states.
package types;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } flittype_t;

    typedef logic [3:0] node_id_t;
    typedef logic [7:0] checksum_t;

    typedef struct packed {
        flittype_t  flit_type;
        logic       is_ack;
        logic       rsvd;
        node_id_t   src_id;
        node_id_t   dst_id;
        logic [3:0] seq;
    } header_t;

    typedef struct packed {
        header_t     header;
        logic [31:0] payload;
        checksum_t   checksum;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } rx_state_t;

    // Byte-wise XOR over header and payload.
    function automatic checksum_t calc_checksum(input header_t h, input logic [31:0] p);
        logic [47:0] d;
        checksum_t   c;
        d = {h, p};
        c = '0;
        for (int i = 0; i < 6; i++) begin
            c = c ^ d[i*8 +: 8];
        end
        return c;
    endfunction

endpackage

// File: rtl/calculate_checksum_comb.sv
// Combinational checksum verifier; passes the flit through unchanged.
module calculate_checksum_comb
    import types::*;
(
    input  flit_t flit_in,
    output flit_t flit_out,
    output logic  is_valid
);

    assign flit_out = flit_in;
    assign is_valid = (calc_checksum(flit_in.header, flit_in.payload) == flit_in.checksum);

endmodule

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with valid/ready on both sides.
module flit_fifo
    import types::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  flit_t       wr_flit,
    input  logic        wr_valid,
    output logic        wr_ready,
    output flit_t       rd_flit,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [AW:0] count
);

    typedef logic [AW:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);

    flit_t          mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           push;
    logic           pop;

    // A pop frees the slot in the same cycle, so a full FIFO can still push.
    assign wr_ready = (count != FULL) || rd_ready;
    assign rd_valid = (count != '0);
    assign rd_flit  = mem[rptr];
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_flit;
    end

endmodule

// File: rtl/flit_rx_checker.sv
// Receive-side checker: stages each flit, verifies checksum, filters broken
// packets and queues the survivors toward reassembly.
module flit_rx_checker
    import types::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  flit_t            in_flit,
    input  logic             in_valid,
    output logic             in_ready,
    output flit_t            out_flit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output node_id_t         err_src_id,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    flit_t     s_flit;
    logic      s_valid;
    flit_t     chk_flit;
    logic      good;
    logic      accept;
    rx_state_t state;
    rx_state_t state_n;
    logic      wr;
    logic      push;
    logic      fifo_wr_ready;
    cnt_t      fifo_count;
    logic      is_head;
    logic      is_tail;
    logic      bad_seen;
    logic      good_seen;

    // Reserve a FIFO slot for whatever sits in S so it can never be refused.
    assign in_ready = (fifo_count + cnt_t'(s_valid)) < DEPTH_C;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_flit  <= '0;
        end else begin
            s_valid <= accept;
            if (accept) s_flit <= in_flit;
        end
    end

    calculate_checksum_comb u_chk (
        .flit_in  (s_flit),
        .flit_out (chk_flit),
        .is_valid (good)
    );

    always_comb begin
        is_head = 1'b0;
        is_tail = 1'b0;
        unique case (1'b1)
            (s_flit.header.flit_type == HEAD): is_head = 1'b1;
            (s_flit.header.flit_type == TAIL): is_tail = 1'b1;
            default: ;
        endcase
    end

    assign bad_seen  = s_valid && !good;
    assign good_seen = s_valid && good;

    always_comb begin
        state_n = state;
        wr      = 1'b0;
        if (bad_seen) begin
            state_n = DISCARD;
        end else if (good_seen && s_flit.header.is_ack) begin
            wr = 1'b1;
        end else if (good_seen) begin
            unique case (state)
                IDLE: begin
                    if (is_head) begin
                        wr      = 1'b1;
                        state_n = RECV;
                    end
                end
                RECV: begin
                    wr = 1'b1;
                    if (is_tail) state_n = IDLE;
                end
                DISCARD: begin
                    if (is_head) begin
                        wr      = 1'b1;
                        state_n = RECV;
                    end else if (is_tail) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            err_pulse  <= 1'b0;
            err_src_id <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            state     <= state_n;
            err_pulse <= bad_seen;
            if (bad_seen) begin
                err_src_id <= s_flit.header.src_id;
                if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
            end
            if (good_seen && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
        end
    end

    assign push = wr && fifo_wr_ready;

    flit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_flit  (chk_flit),
        .wr_valid (push),
        .wr_ready (fifo_wr_ready),
        .rd_flit  (out_flit),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_flit_rx_checker.sv
// Directed bench for flit_rx_checker: filtering, backpressure, reset, saturation.
module tb_flit_rx_checker;
    import types::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    flit_t         in_flit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    flit_t         out_flit;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          err_pulse;
    node_id_t      err_src_id;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] bad_cnt;

    int    checks = 0;
    int    errors = 0;
    flit_t got_q[$];
    int    err_cycles = 0;

    always #5 clk = ~clk;

    flit_rx_checker #(
        .FIFO_DEPTH (4),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_pulse  (err_pulse),
        .err_src_id (err_src_id),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got_q.push_back(out_flit);
            if (err_pulse) err_cycles++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic flit_t mk(flittype_t t, logic ack, node_id_t src, logic [31:0] pl);
        flit_t       f;
        logic [47:0] d;
        f = '0;
        f.header.flit_type = t;
        f.header.is_ack    = ack;
        f.header.src_id    = src;
        f.payload          = pl;
        d = {f.header, f.payload};
        for (int i = 0; i < 6; i++) f.checksum = f.checksum ^ d[i*8 +: 8];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input flit_t f);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_flit = f;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        got_q.delete();
        err_cycles = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        idle(2);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse: got %b expected 0", err_pulse); end
        checks++;
        if (err_src_id !== 4'h0) begin errors++; $display("FAIL rst_err_src: got %h expected 0", err_src_id); end
        checks++;
        if (good_cnt !== 4'd0 || bad_cnt !== 4'd0) begin
            errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", good_cnt, bad_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        got_q.delete();
        err_cycles = 0;
    endtask

    task automatic test_single_head();
        flit_t f;
        do_reset();
        out_ready = 1'b1;
        f = '0;
        send(f);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got out_valid=%b expected 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_flit !== 56'h0) begin errors++; $display("FAIL lat_flit: got %h expected 0", out_flit); end
        checks++;
        if (good_cnt !== 4'd1) begin errors++; $display("FAIL lat_good: got %0d expected 1", good_cnt); end
        idle(3);
        checks++;
        if (got_q.size() != 1 || err_cycles != 0) begin
            errors++; $display("FAIL lat_count: got %0d flits %0d errs expected 1/0", got_q.size(), err_cycles);
        end
    endtask

    task automatic test_back_to_back();
        flit_t fs[3];
        do_reset();
        out_ready = 1'b1;
        fs[0] = mk(HEAD, 1'b0, 4'd3, 32'h1111_1111);
        fs[1] = mk(BODY, 1'b0, 4'd3, 32'h2222_2222);
        fs[2] = mk(TAIL, 1'b0, 4'd3, 32'h3333_3333);
        for (int i = 0; i < 3; i++) send(fs[i]);
        idle(4);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL b2b_size: got %0d expected 3", got_q.size()); end
        if (got_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== fs[i]) begin
                    errors++; $display("FAIL b2b_flit%0d: got %h expected %h", i, got_q[i], fs[i]);
                end
            end
        end
        checks++;
        if (good_cnt !== 4'd3) begin errors++; $display("FAIL b2b_good: got %0d expected 3", good_cnt); end
        send(mk(BODY, 1'b0, 4'd3, 32'h4444_4444));
        idle(3);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL b2b_orphan: got %0d flits expected 3", got_q.size()); end
        checks++;
        if (good_cnt !== 4'd4) begin errors++; $display("FAIL b2b_good2: got %0d expected 4", good_cnt); end
    endtask

    task automatic test_bad_checksum();
        flit_t h1, bb, b2, t, h2;
        do_reset();
        out_ready = 1'b1;
        h1 = mk(HEAD, 1'b0, 4'd3, 32'hA000_0001);
        bb = mk(BODY, 1'b0, 4'd3, 32'hA000_0002);
        bb.checksum[0] = ~bb.checksum[0];
        b2 = mk(BODY, 1'b0, 4'd3, 32'hA000_0003);
        t  = mk(TAIL, 1'b0, 4'd3, 32'hA000_0004);
        h2 = mk(HEAD, 1'b0, 4'd3, 32'hA000_0005);
        send(h1);
        send(bb);
        send(b2);
        send(t);
        send(h2);
        idle(4);
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL bad_size: got %0d expected 2", got_q.size()); end
        if (got_q.size() == 2) begin
            checks++;
            if (got_q[0] !== h1) begin errors++; $display("FAIL bad_first: got %h expected %h", got_q[0], h1); end
            checks++;
            if (got_q[1] !== h2) begin errors++; $display("FAIL bad_second: got %h expected %h", got_q[1], h2); end
        end
        checks++;
        if (err_cycles != 1) begin errors++; $display("FAIL bad_pulse: got %0d cycles expected 1", err_cycles); end
        checks++;
        if (err_src_id !== 4'd3) begin errors++; $display("FAIL bad_src: got %h expected 3", err_src_id); end
        checks++;
        if (bad_cnt !== 4'd1) begin errors++; $display("FAIL bad_cnt: got %0d expected 1", bad_cnt); end
        checks++;
        if (good_cnt !== 4'd4) begin errors++; $display("FAIL bad_good: got %0d expected 4", good_cnt); end
    endtask

    task automatic test_backpressure();
        flit_t fs[6];
        int    idx;
        bit    acc;
        bit    moved;
        do_reset();
        out_ready = 1'b0;
        fs[0] = mk(HEAD, 1'b0, 4'd5, 32'hB000_0000);
        for (int i = 1; i < 5; i++) fs[i] = mk(BODY, 1'b0, 4'd5, 32'hB000_0000 + i);
        fs[5] = mk(TAIL, 1'b0, 4'd5, 32'hB000_0005);
        idx = 0;
        moved = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 6);
            in_flit  = fs[(idx < 6) ? idx : 5];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_flit !== fs[0]) moved = 1'b1;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_flit !== fs[0]) begin
            errors++; $display("FAIL bp_head: got %b/%h expected 1/%h", out_valid, out_flit, fs[0]);
        end
        checks++;
        if (moved) begin errors++; $display("FAIL bp_stable: got changing out_flit expected %h", fs[0]); end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            in_valid = 1'b1;
            in_flit  = fs[idx];
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        idle(6);
        checks++;
        if (got_q.size() != 6) begin errors++; $display("FAIL bp_drain: got %0d expected 6", got_q.size()); end
        if (got_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_q[i] !== fs[i]) begin
                    errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got_q[i], fs[i]);
                end
            end
        end
        checks++;
        if (good_cnt !== 4'd6) begin errors++; $display("FAIL bp_good: got %0d expected 6", good_cnt); end
    endtask

    task automatic test_ack_discard();
        flit_t bad, ack, body, hd;
        do_reset();
        out_ready = 1'b1;
        bad = mk(BODY, 1'b0, 4'd6, 32'hC000_0001);
        bad.checksum = bad.checksum ^ 8'h80;
        ack  = mk(BODY, 1'b1, 4'd6, 32'hC000_0002);
        body = mk(BODY, 1'b0, 4'd6, 32'hC000_0003);
        hd   = mk(HEAD, 1'b0, 4'd6, 32'hC000_0004);
        send(bad);
        send(ack);
        send(body);
        idle(4);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL ack_size: got %0d expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++;
            if (got_q[0] !== ack) begin errors++; $display("FAIL ack_flit: got %h expected %h", got_q[0], ack); end
        end
        checks++;
        if (good_cnt !== 4'd2 || bad_cnt !== 4'd1) begin
            errors++; $display("FAIL ack_cnt: got %0d/%0d expected 2/1", good_cnt, bad_cnt);
        end
        checks++;
        if (err_src_id !== 4'd6) begin errors++; $display("FAIL ack_src: got %h expected 6", err_src_id); end
        send(hd);
        idle(3);
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL ack_head: got %0d expected 2", got_q.size()); end
    endtask

    task automatic test_reset_midflight();
        flit_t bad;
        do_reset();
        out_ready = 1'b0;
        bad = mk(BODY, 1'b0, 4'd7, 32'hD000_0003);
        bad.checksum = bad.checksum ^ 8'h01;
        send(mk(HEAD, 1'b0, 4'd2, 32'hD000_0001));
        send(mk(BODY, 1'b0, 4'd2, 32'hD000_0002));
        send(bad);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (good_cnt !== 4'd0 || bad_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_cnt: got %0d/%0d expected 0/0", good_cnt, bad_cnt);
        end
        idle(2);
        checks++;
        if (err_cycles != 0 || err_src_id !== 4'h0) begin
            errors++; $display("FAIL mid_err: got %0d pulses src %h expected 0/0", err_cycles, err_src_id);
        end
        out_ready = 1'b1;
        send(mk(BODY, 1'b0, 4'd2, 32'hD000_0004));
        idle(3);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL mid_orphan: got %0d flits expected 0", got_q.size()); end
        checks++;
        if (good_cnt !== 4'd1) begin errors++; $display("FAIL mid_good: got %0d expected 1", good_cnt); end
    endtask

    task automatic test_saturation();
        flit_t f;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(mk(BODY, 1'b1, 4'd1, 32'hE000_0000 + i));
        for (int i = 0; i < 17; i++) begin
            f = mk(BODY, 1'b0, 4'd9, 32'hF000_0000 + i);
            f.checksum = f.checksum ^ 8'h01;
            send(f);
        end
        idle(3);
        checks++;
        if (good_cnt !== 4'hF) begin errors++; $display("FAIL sat_good: got %0d expected 15", good_cnt); end
        checks++;
        if (bad_cnt !== 4'hF) begin errors++; $display("FAIL sat_bad: got %0d expected 15", bad_cnt); end
        checks++;
        if (got_q.size() != 17) begin errors++; $display("FAIL sat_fwd: got %0d expected 17", got_q.size()); end
        checks++;
        if (err_src_id !== 4'd9) begin errors++; $display("FAIL sat_src: got %h expected 9", err_src_id); end
    endtask

    initial begin
        test_reset();
        test_single_head();
        test_back_to_back();
        test_bad_checksum();
        test_backpressure();
        test_ack_discard();
        test_reset_midflight();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
